// File: rtl/axilite_bresp_fifo.sv
// AXI-Lite B-channel response queue with sticky error monitor.
// Responses leave in acceptance order; no bypass from push to bresp.
module axilite_bresp_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       resp,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic             bready,
  output logic             bvalid,
  output logic [1:0]       bresp,
  output logic [CNT_W-1:0] count,
  output logic             err_sticky,
  input  logic             err_clear
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             push;
  logic             pop;

  assign resp_ready = (count != CNT_W'(DEPTH));
  assign bvalid     = (count != '0);
  assign push       = resp_valid && resp_ready;
  assign pop        = bvalid && bready;
  assign bresp      = bvalid ? mem[rptr] : 2'b00;

  // Storage needs no reset; empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= resp;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (push && resp[1]) begin
      err_sticky <= 1'b1;
    end else if (err_clear) begin
      err_sticky <= 1'b0;
    end
  end

endmodule

// File: doc/axilite_bresp_fifo.md
# axilite_bresp_fifo

Buffered AXI-Lite write-response (B) channel source. Accepts 2-bit write responses from the internal register/write logic and queues up to DEPTH of them, presenting each in order on the AXI B channel. Unlike the single-entry B responder, the internal side keeps completing writes while the master stalls `bready`, and an error monitor records any SLVERR/DECERR responses for the control-status logic.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of `count`; derived, not overridden.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- resp  in  2  internal write response (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR).
- resp_valid  in  1  `resp` is valid this cycle.
- resp_ready  out  1  block can accept a response; equals `count != DEPTH`.
- bready  in  1  AXI master ready.
- bvalid  out  1  AXI B valid; equals `count != 0`.
- bresp  out  2  AXI B response; queue head, 00 when empty.
- count  out  CNT_W  number of queued responses.
- err_sticky  out  1  set once any accepted response has `resp[1]` = 1.
- err_clear  in  1  synchronous clear of `err_sticky`.

## Operation
- Circular buffer of DEPTH x 2 bits, write pointer, read pointer (log2(DEPTH) bits, wrap naturally), occupancy register `count`.
- Push: `resp_valid && resp_ready`; writes `resp` at write pointer, pointer +1.
- Pop: `bvalid && bready`; read pointer +1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push and pop in the same cycle are legal whenever neither is individually blocked (count neither 0 nor DEPTH). Full: push blocked even if pop occurs (no bypass). Empty: pop impossible. The new entry is not visible on `bresp` in the same cycle.
- `resp_valid` while `resp_ready` = 0: no write, no state change. The producer holds `resp`.
- `bresp` is combinational from the entry at the read pointer, gated to 00 when empty. It stays stable while `bvalid && !bready`, as AXI requires.
- Responses leave in acceptance order. No reordering or merging.
- err_sticky: set on a push with `resp[1]` = 1; cleared by `err_clear`; if both occur in the same cycle, set wins.
- EXOKAY is passed through unchanged and does not set `err_sticky`.

## Timing
- Reset values (asynchronous, immediate): count 0, pointers 0, bvalid 0, bresp 00, resp_ready 1, err_sticky 0. Buffer contents need no reset.
- Reset mid-operation discards all queued responses. The master sees `bvalid` drop during reset; this is accepted, since the interconnect is reset together with the block.
- Latency: a response pushed at edge N gives `bvalid` = 1 and `bresp` = that value after edge N, i.e. one cycle after `resp_valid`.
- Throughput: one push and one pop per cycle sustained. With `bready` held high and one response per cycle, `count` stays at 1.
- `resp_ready` falls in the cycle after the push that fills the queue. It rises in the cycle after the first pop from full.
- `err_sticky` updates at the edge of the accepting push, so it is visible with the same latency as `bvalid`.

## Test plan
- Single: reset, push `resp` = 10 with `bready` = 0 -> next cycle bvalid = 1, bresp = 10, count = 1, err_sticky = 1. Hold 3 cycles with bresp stable, then raise bready -> after one edge bvalid = 0, bresp = 00, count = 0.
- Fill/full (DEPTH = 4): push 00, 01, 10, 11 with bready = 0 -> count = 4, resp_ready = 0. Drive a 5th push of 01 -> ignored. Drain -> bresp sequence 00, 01, 10, 11, then empty.
- Simultaneous: count = 2, push 11 with bready = 1 -> count stays 2, head advances, 11 appears last. At full with bready = 1 and resp_valid = 1 -> push rejected, count = 3.
- Wrap: 10 fill/drain cycles with mixed patterns -> output order matches input order across pointer wrap. Count never exceeds 4 or goes below 0.
- Error flag: push only 00/01 -> err_sticky = 0. Assert err_clear in the same cycle as a push of 11 -> err_sticky = 1. Assert err_clear alone -> 0.
- Async reset: with count = 3, pulse rst between clock edges -> bvalid, count, and err_sticky drop to 0 immediately. After release, first push appears with 1-cycle latency.
